mdu_div_iter: RTL
=================

# mdu_div_iter

Parametrised iterative integer divider for the MDU issue path, replacing the fixed 32-bit divide wrapper. Accepts one signed/unsigned DIV/MOD request per handshake, computes quotient or remainder with a restoring radix-2 loop, and returns the result with its ROB tag through a valid/ready output. Special cases complete early, and flush kills in-flight work.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be ≥ 8, power of two not required.
- TAG_W, 6, width of the ROB tag carried alongside the operation.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; kills any held or in-flight op.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i && ready_o.
- op_i  in  2  0=DIV (signed quotient), 1=DIVU, 2=MOD (signed remainder), 3=MODU.
- tag_i  in  TAG_W  ROB tag of the request.
- num0_i  in  XLEN  dividend.
- num1_i  in  XLEN  divisor.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready; result retires when valid_o && ready_i.
- data_o  out  XLEN  quotient or remainder per op.
- tag_o  out  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, CALC, DONE. At most one op is outstanding.
- IDLE: ready_o=1. On accept, latch op, tag, sign flags, |num0|, |num1|; the counter loads the iteration count. Normal ops go to CALC; special cases go to DONE with the result preloaded.
- Special cases:
  - divisor 0: quotient = all ones, remainder = num0.
  - Signed DIV/MOD with num0 = 2^(XLEN-1) and num1 = all ones: quotient = num0, remainder = 0.
- CALC: each cycle shift the partial remainder left by one, taking the next dividend bit. If partial ≥ |divisor|, subtract it and shift 1 into the quotient, else shift 0. Decrement the counter. When the counter reaches 0, go to DONE.
- Arithmetic:
  - The partial remainder is XLEN+1 bits wide.
  - Sign correction is applied on entry to DONE: the quotient is negated if signed and the operand signs differ; the remainder takes the dividend's sign.
  - Unsigned ops never negate.
- DONE: valid_o=1, and data_o/tag_o are stable until the output handshake.
  - On handshake: if valid_i is also high, accept the new request in the same cycle (ready_o=ready_i in DONE); otherwise return to IDLE.
- flush, any state: next state is IDLE. Any accept in that cycle is ignored (ready_o is still driven, but no op is captured).
- rst: state IDLE, valid_o=0, ready_o=1 in the next cycle, data_o=0, tag_o=0, counter 0.

## Timing
- Accept in cycle T.
  - Normal op: CALC occupies T+1..T+N, and valid_o first rises in cycle T+N+1. N = XLEN (macro off).
  - Special case: valid_o rises in cycle T+1.
- ready_o depends combinationally on ready_i only in DONE; there is no other input-to-output combinational path.
- Throughput with ready_i held high: one op per N+1 cycles (back-to-back via the DONE accept).
- If the output is stalled (ready_i=0), DONE holds indefinitely and ready_o=0.
- flush and the output handshake in the same cycle: flush wins and the result is dropped; the consumer must ignore it.

## Configuration
- MDU_DIV_EARLY_OUT_EN:
  - Defined: at accept, N = max(1, XLEN − lzc(|num0|)), and the dividend is pre-shifted left by lzc so the leading zero bits are skipped. Results are bit-identical to the macro-off case; only latency shrinks.
  - Undefined: N = XLEN always, and no leading-zero counter is built.

## Test plan
- DIVU, XLEN=32: num0=100, num1=7, op=1, tag=5 → data_o=14, tag_o=5, valid_o in cycle T+33 (macro off) or T+8 (macro on).
- Signed: DIV num0=−7, num1=2 → −3 (0xFFFFFFFD); MOD num0=−7, num1=2 → −1; MOD num0=7, num1=−2 → 1.
- Divide by zero: DIV 42/0 → 0xFFFFFFFF; MODU 42/0 → 42; both at latency 1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; MOD same operands → 0; latency 1.
- Backpressure plus back-to-back: hold ready_i=0 for 5 cycles in DONE → data_o/tag_o stable and ready_o=0. Then raise ready_i with valid_i=1 → result retires and the new op is accepted in the same cycle.
- flush mid-CALC (cycle T+10) → valid_o never rises for that tag, ready_o=1 in the next cycle, and the next request completes correctly. Also run rst mid-CALC → same idle outputs, data_o=0.

Source files
------------

// File: rtl/mdu_div_iter.sv
// mdu_div_iter -- iterative restoring radix-2 integer divider for the MDU.
//
// Accepts one DIV/DIVU/MOD/MODU request per valid/ready handshake, runs one
// quotient bit per cycle and returns the quotient or remainder together with
// the ROB tag through a valid/ready output. Divide-by-zero and signed
// overflow finish one cycle after accept. flush kills any held or in-flight op.
//
// Optional build macro: MDU_DIV_EARLY_OUT_EN
//   defined   : leading zeros of |dividend| are skipped, so the loop runs
//               max(1, XLEN - lzc) iterations (results unchanged)
//   undefined : the loop always runs XLEN iterations, no leading-zero counter
//
// Parameters:
//   XLEN   operand/result width (>= 8)
//   TAG_W  ROB tag width
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   flush    in   pipeline flush, returns to IDLE and drops any op
//   valid_i  in   request valid
//   ready_o  out  request ready (1 in IDLE, ready_i in DONE, 0 in CALC)
//   op_i     in   0=DIV 1=DIVU 2=MOD 3=MODU
//   tag_i    in   ROB tag of request
//   num0_i   in   dividend
//   num1_i   in   divisor
//   valid_o  out  result valid
//   ready_i  in   consumer ready
//   data_o   out  quotient or remainder
//   tag_o    out  tag of result
module mdu_div_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [XLEN-1:0]  num0_i,
  input  logic [XLEN-1:0]  num1_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  data_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement negation.
  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
    return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

`ifdef MDU_DIV_EARLY_OUT_EN
  // Number of leading zero bits; XLEN for a zero operand.
  function automatic logic [CNT_W-1:0] lzc(input logic [XLEN-1:0] x);
    logic [CNT_W-1:0] n;
    logic             found;
    n     = {CNT_W{1'b0}};
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found && !x[i]) begin
        n = n + CNT_W'(1);
      end else begin
        found = 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // State and datapath registers
  state_t            state_r;
  state_t            state_nxt_s;
  logic              valid_r;
  logic [TAG_W-1:0]  tag_r;
  logic [XLEN-1:0]   data_r;
  logic [XLEN:0]     partial_r;   // partial remainder
  logic [XLEN-1:0]   dividend_r;  // dividend bits out at the top, quotient bits in at the bottom
  logic [XLEN-1:0]   divisor_r;   // |divisor|
  logic [CNT_W-1:0]  cnt_r;
  logic              q_neg_r;
  logic              r_neg_r;
  logic              is_mod_r;

  // Request-side combinational signals
  logic              accept_s;
  logic              ready_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   abs_a_s;
  logic [XLEN-1:0]   abs_b_s;
  logic              div_zero_s;
  logic              ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;
  logic [XLEN-1:0]   start_dividend_s;
  logic [CNT_W-1:0]  iter_s;

  // Iteration-side combinational signals
  logic [XLEN:0]     pshift_s;
  logic [XLEN+1:0]   diff_s;
  logic              ge_s;
  logic [XLEN:0]     pnext_s;
  logic [XLEN-1:0]   qnext_s;
  logic [XLEN-1:0]   fin_q_s;
  logic [XLEN-1:0]   fin_r_s;
  logic [XLEN-1:0]   result_s;

`ifdef MDU_DIV_EARLY_OUT_EN
  logic [CNT_W-1:0]  lz_s;
`endif

  // Operand preparation at accept: signs, magnitudes, special cases, loop length
  always_comb begin
    a_neg_s       = ~op_i[0] & num0_i[XLEN-1];
    b_neg_s       = ~op_i[0] & num1_i[XLEN-1];
    abs_a_s       = a_neg_s ? twos_neg(num0_i) : num0_i;
    abs_b_s       = b_neg_s ? twos_neg(num1_i) : num1_i;
    div_zero_s    = (num1_i == {XLEN{1'b0}});
    ovf_s         = ~op_i[0] & (num0_i == {1'b1, {(XLEN-1){1'b0}}}) &
                    (num1_i == {XLEN{1'b1}});
    special_s     = div_zero_s | ovf_s;
    special_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      // x/0: quotient all ones, remainder is the raw dividend
      special_res_s = op_i[1] ? num0_i : {XLEN{1'b1}};
    end else if (ovf_s) begin
      // MIN/-1: quotient wraps to MIN, remainder is zero
      special_res_s = op_i[1] ? {XLEN{1'b0}} : num0_i;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
`ifdef MDU_DIV_EARLY_OUT_EN
    lz_s = lzc(abs_a_s);
    // Skip the leading zeros; a zero dividend still runs one iteration
    if (lz_s == CNT_W'(XLEN)) begin
      iter_s = CNT_W'(1);
    end else begin
      iter_s = CNT_W'(XLEN) - lz_s;
    end
    start_dividend_s = abs_a_s << lz_s;
`else
    iter_s           = CNT_W'(XLEN);
    start_dividend_s = abs_a_s;
`endif
  end

  // One restoring step plus sign correction of the final step's result
  always_comb begin
    pshift_s = {partial_r[XLEN-1:0], dividend_r[XLEN-1]};
    diff_s   = {1'b0, pshift_s} - {2'b00, divisor_r};
    // A set top partial bit already exceeds any XLEN-bit divisor
    ge_s     = ~diff_s[XLEN+1] | partial_r[XLEN];
    if (ge_s) begin
      pnext_s = diff_s[XLEN:0];
    end else begin
      pnext_s = pshift_s;
    end
    qnext_s  = {dividend_r[XLEN-2:0], ge_s};
    fin_q_s  = q_neg_r ? twos_neg(qnext_s) : qnext_s;
    fin_r_s  = r_neg_r ? twos_neg(pnext_s[XLEN-1:0]) : pnext_s[XLEN-1:0];
    result_s = is_mod_r ? fin_r_s : fin_q_s;
  end

  // Next-state, accept and ready decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    ready_s     = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (valid_i) begin
          accept_s    = 1'b1;
          state_nxt_s = special_s ? DONE : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        ready_s = 1'b0;
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        // Result retires on ready_i; a waiting request is taken in the same cycle
        ready_s = ready_i;
        if (ready_i) begin
          if (valid_i) begin
            accept_s    = 1'b1;
            state_nxt_s = special_s ? DONE : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        ready_s     = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
    // flush overrides everything; ready_o stays as decoded but nothing is captured
    if (flush) begin
      state_nxt_s = IDLE;
      accept_s    = 1'b0;
    end else begin
      accept_s    = accept_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: operand capture, iteration, result and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      tag_r      <= {TAG_W{1'b0}};
      data_r     <= {XLEN{1'b0}};
      partial_r  <= {(XLEN+1){1'b0}};
      dividend_r <= {XLEN{1'b0}};
      divisor_r  <= {XLEN{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      is_mod_r   <= 1'b0;
    end else begin
      valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        tag_r      <= tag_i;
        q_neg_r    <= a_neg_s ^ b_neg_s;
        r_neg_r    <= a_neg_s;
        is_mod_r   <= op_i[1];
        divisor_r  <= abs_b_s;
        dividend_r <= start_dividend_s;
        partial_r  <= {(XLEN+1){1'b0}};
        cnt_r      <= iter_s;
        if (special_s) begin
          data_r <= special_res_s;
        end else begin
          data_r <= data_r;
        end
      end else if (state_r == CALC) begin
        partial_r  <= pnext_s;
        dividend_r <= qnext_s;
        cnt_r      <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          data_r <= result_s;
        end else begin
          data_r <= data_r;
        end
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign ready_o = ready_s;
  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign tag_o   = tag_r;

endmodule
